jesd_octet_align: RTL and testbench



---
 rtl/jesd_octet_align.sv | 185 ++++++++++++++++++
 tb/tb_jesd_octet_align.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/jesd_octet_align.sv
// ============================================================================
// Module      : jesd_octet_align
// Description : Lane octet aligner: finds the K28.5 boundary in a NOCT-octet
//               parallel word during CGS, verifies it, then locks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jesd_octet_align #(
    parameter int          NOCT    = 4,
    parameter logic [7:0]  K_CHAR  = 8'hBC,
    parameter int          CGS_MIN = 4,
    localparam int         AW      = (NOCT <= 2) ? 1 : $clog2(NOCT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync_n,
    input  logic [8*NOCT-1:0]   in,
    input  logic [NOCT-1:0]     charisk,
    output logic [8*NOCT-1:0]   o,
    output logic [NOCT-1:0]     datak,
    output logic [AW-1:0]       align,
    output logic                locked,
    output logic [7:0]          err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_VERIFY = 2'd2,
        S_LOCK   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;

    logic [8*NOCT-1:0]   r_d0;
    logic [8*NOCT-1:0]   r_d1;
    logic [NOCT-1:0]     r_k0;
    logic [NOCT-1:0]     r_k1;
    logic [8*NOCT-1:0]   r_o;
    logic [NOCT-1:0]     r_datak;
    logic [AW-1:0]       r_align;
    logic                r_locked;
    logic [7:0]          r_err;
    logic [7:0]          r_vcnt;
    logic                r_sync_q;

    logic [AW-1:0]       w_align_nx;
    logic                w_locked_nx;
    logic [7:0]          w_err_nx;
    logic [7:0]          w_vcnt_nx;
    logic [7:0]          w_vcnt_inc;

    logic [8*NOCT-1:0]   w_opt_d [NOCT];
    logic [NOCT-1:0]     w_opt_k [NOCT];
    logic [8*NOCT-1:0]   w_cand_d;
    logic [NOCT-1:0]     w_cand_k;
    logic [NOCT-1:0]     w_cand_isk;
    logic                w_cand_allk;
    logic [NOCT-1:0]     w_d1_isk;
    logic [AW-1:0]       w_first_k;

    // Every possible offset of the two-word octet stream {d0,d1}.
    for (genvar a = 0; a < NOCT; a++) begin : g_ofs
        if (a == 0) begin : g_zero
            assign w_opt_d[a] = r_d1;
            assign w_opt_k[a] = r_k1;
        end else begin : g_shift
            assign w_opt_d[a] = {r_d0[8*a-1:0], r_d1[8*NOCT-1:8*a]};
            assign w_opt_k[a] = {r_k0[a-1:0], r_k1[NOCT-1:a]};
        end
    end

    assign w_cand_d = w_opt_d[r_align];
    assign w_cand_k = w_opt_k[r_align];

    for (genvar i = 0; i < NOCT; i++) begin : g_kdet
        assign w_d1_isk[i]   = (r_d1[8*i +: 8] == K_CHAR) && r_k1[i];
        assign w_cand_isk[i] = (w_cand_d[8*i +: 8] == K_CHAR) && w_cand_k[i];
    end

    assign w_cand_allk = &w_cand_isk;
    assign w_vcnt_inc  = r_vcnt + 8'd1;

    always_comb begin
        w_first_k = '0;
        for (int i = NOCT - 1; i >= 0; i--) begin
            if (w_d1_isk[i]) begin
                w_first_k = AW'(i);
            end
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_align_nx  = r_align;
        w_locked_nx = r_locked;
        w_err_nx    = r_err;
        w_vcnt_nx   = r_vcnt;
        case (r_state)
            S_IDLE: begin
                w_locked_nx = 1'b0;
                if (!sync_n) begin
                    w_state_nx = S_SEARCH;
                end
            end
            S_SEARCH: begin
                w_locked_nx = 1'b0;
                if (sync_n) begin
                    w_state_nx = S_IDLE;
                end else if (|w_d1_isk) begin
                    w_align_nx = w_first_k;
                    w_vcnt_nx  = 8'd0;
                    w_state_nx = S_VERIFY;
                end
            end
            S_VERIFY: begin
                // Reaching the lock count outranks a simultaneous SYNC~ release.
                if (w_cand_allk && (w_vcnt_inc == 8'(CGS_MIN))) begin
                    w_vcnt_nx   = w_vcnt_inc;
                    w_locked_nx = 1'b1;
                    w_state_nx  = S_LOCK;
                end else if (sync_n) begin
                    w_state_nx = S_IDLE;
                end else if (w_cand_allk) begin
                    w_vcnt_nx = w_vcnt_inc;
                end else begin
                    w_err_nx   = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
                    w_state_nx = S_SEARCH;
                end
            end
            S_LOCK: begin
                w_locked_nx = 1'b1;
                if (r_sync_q && !sync_n) begin
                    w_locked_nx = 1'b0;
                    w_state_nx  = S_SEARCH;
                end
            end
            default: begin
                w_locked_nx = 1'b0;
                w_state_nx  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_d0     <= '0;
            r_d1     <= '0;
            r_k0     <= '0;
            r_k1     <= '0;
            r_o      <= '0;
            r_datak  <= '0;
            r_align  <= '0;
            r_locked <= 1'b0;
            r_err    <= 8'd0;
            r_vcnt   <= 8'd0;
            r_sync_q <= 1'b1;
        end else begin
            r_state  <= w_state_nx;
            r_d0     <= in;
            r_d1     <= r_d0;
            r_k0     <= charisk;
            r_k1     <= r_k0;
            r_o      <= w_cand_d;
            r_datak  <= w_cand_k;
            r_align  <= w_align_nx;
            r_locked <= w_locked_nx;
            r_err    <= w_err_nx;
            r_vcnt   <= w_vcnt_nx;
            r_sync_q <= sync_n;
        end
    end

    assign o       = r_o;
    assign datak   = r_datak;
    assign align   = r_align;
    assign locked  = r_locked;
    assign err_cnt = r_err;

endmodule

`default_nettype wire

// File: tb/tb_jesd_octet_align.sv
// ============================================================================
// Module      : tb_jesd_octet_align
// Description : Directed bench for jesd_octet_align (NOCT=4/CGS_MIN=4 and
//               NOCT=2/CGS_MIN=1 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jesd_octet_align;

    logic        clk;
    logic        rst_n;

    logic        sync_n;
    logic [31:0] din;
    logic [3:0]  kin;
    logic [31:0] o1;
    logic [3:0]  datak1;
    logic [1:0]  align1;
    logic        locked1;
    logic [7:0]  err1;

    logic        sync2;
    logic [15:0] din2;
    logic [1:0]  kin2;
    logic [15:0] o2;
    logic [1:0]  datak2;
    logic [0:0]  align2;
    logic        locked2;
    logic [7:0]  err2;

    int n_cmp = 0;
    int n_bad = 0;

    jesd_octet_align #(.NOCT(4), .K_CHAR(8'hBC), .CGS_MIN(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .sync_n(sync_n), .in(din), .charisk(kin),
        .o(o1), .datak(datak1), .align(align1), .locked(locked1), .err_cnt(err1)
    );

    jesd_octet_align #(.NOCT(2), .K_CHAR(8'hBC), .CGS_MIN(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .sync_n(sync2), .in(din2), .charisk(kin2),
        .o(o2), .datak(datak2), .align(align2), .locked(locked2), .err_cnt(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sync_n = 1'b1; din = 32'h04030201; kin = 4'h0;
        sync2 = 1'b1;  din2 = 16'h0000;    kin2 = 2'b00;
        tick(2);
        check("rst_o",      o1, 32'h0);
        check("rst_datak",  {28'h0, datak1}, 32'h0);
        check("rst_locked", {31'h0, locked1}, 32'h0);
        check("rst_err",    {24'h0, err1}, 32'h0);
        check("rst_o2",     {16'h0, o2}, 32'h0);

        // Pass-through with sync_n high, 3-clock latency
        rst_n = 1'b1;
        tick(2);
        check("lat_o_early", o1, 32'h0);
        tick(1);
        check("pass_o",      o1, 32'h04030201);
        check("pass_datak",  {28'h0, datak1}, 32'h0);
        check("pass_align",  {30'h0, align1}, 32'h0);
        check("pass_locked", {31'h0, locked1}, 32'h0);
        tick(2);

        // CGS with K first seen in octets 2..3
        sync_n = 1'b0; din = 32'h00112233; kin = 4'h0; tick(1);
        din = 32'hBCBC5566; kin = 4'hC; tick(1);
        din = 32'hBCBCBCBC; kin = 4'hF; tick(2);
        check("t2_align",  {30'h0, align1}, 32'd2);
        check("t2_unlock", {31'h0, locked1}, 32'h0);
        tick(3);
        check("t2_notyet", {31'h0, locked1}, 32'h0);
        tick(1);
        check("t2_locked", {31'h0, locked1}, 32'h1);
        check("t2_o",      o1, 32'hBCBCBCBC);
        check("t2_datak",  {28'h0, datak1}, 32'hF);
        check("t2_err",    {24'h0, err1}, 32'h0);

        // Re-sync, K first seen in octet 3, then data phase
        sync_n = 1'b1; din = 32'h00112233; kin = 4'h0; tick(1);
        check("t3_hold", {31'h0, locked1}, 32'h1);
        tick(1);
        sync_n = 1'b0; tick(1);
        check("t3_drop", {31'h0, locked1}, 32'h0);
        din = 32'hBC112233; kin = 4'h8; tick(1);
        din = 32'hBCBCBCBC; kin = 4'hF; tick(2);
        check("t3_align", {30'h0, align1}, 32'd3);
        tick(3);
        check("t3_notyet", {31'h0, locked1}, 32'h0);
        tick(1);
        check("t3_locked", {31'h0, locked1}, 32'h1);
        sync_n = 1'b1; din = 32'hDDCCBBAA; kin = 4'h0; tick(1);
        din = 32'h44332211; tick(2);
        check("t3_o",      o1, 32'h332211DD);
        check("t3_datak",  {28'h0, datak1}, 32'h0);
        check("t3_locked_data", {31'h0, locked1}, 32'h1);

        // Verify failure: K_CHAR value with charisk=0 in octet 1
        din = 32'h00112233; kin = 4'h0; tick(1);
        sync_n = 1'b0; tick(1);
        check("t4_drop", {31'h0, locked1}, 32'h0);
        din = 32'hBCBCBCBC; kin = 4'hF; tick(3);
        check("t4_align", {30'h0, align1}, 32'd0);
        din = 32'hBCBCBCBC; kin = 4'b1101; tick(1);
        din = 32'hBCBCBCBC; kin = 4'hF; tick(1);
        check("t4_err_pre", {24'h0, err1}, 32'h0);
        tick(1);
        check("t4_err",     {24'h0, err1}, 32'h1);
        check("t4_unlock",  {31'h0, locked1}, 32'h0);
        tick(4);
        check("t4_notyet",  {31'h0, locked1}, 32'h0);
        tick(1);
        check("t4_relock",  {31'h0, locked1}, 32'h1);

        // Long data phase, then falling SYNC~ re-acquires at offset 1
        sync_n = 1'b1; din = 32'h00112233; kin = 4'h0; tick(10);
        check("t5_hold", {31'h0, locked1}, 32'h1);
        sync_n = 1'b0; tick(1);
        check("t5_drop", {31'h0, locked1}, 32'h0);
        din = 32'hBCBCBC11; kin = 4'hE; tick(1);
        din = 32'hBCBCBCBC; kin = 4'hF; tick(2);
        check("t5_align", {30'h0, align1}, 32'd1);
        tick(2);
        #1 rst_n = 1'b0;
        #1;
        check("t5_arst_o",      o1, 32'h0);
        check("t5_arst_datak",  {28'h0, datak1}, 32'h0);
        check("t5_arst_align",  {30'h0, align1}, 32'h0);
        check("t5_arst_locked", {31'h0, locked1}, 32'h0);
        check("t5_arst_err",    {24'h0, err1}, 32'h0);
        #1 rst_n = 1'b1;
        sync_n = 1'b1;
        tick(1);

        // NOCT=2, CGS_MIN=1: K first in octet 1
        sync2 = 1'b0; din2 = 16'h0000; kin2 = 2'b00; tick(1);
        din2 = 16'hBC00; kin2 = 2'b10; tick(1);
        din2 = 16'hBCBC; kin2 = 2'b11; tick(2);
        check("t6_align",  {31'h0, align2}, 32'd1);
        check("t6_unlock", {31'h0, locked2}, 32'h0);
        tick(1);
        check("t6_locked", {31'h0, locked2}, 32'h1);
        check("t6_o",      {16'h0, o2}, 32'hBCBC);
        check("t6_datak",  {30'h0, datak2}, 32'h3);

        // Repeated verify failures drive err_cnt into saturation
        din2 = 16'h00BC; kin2 = 2'b01; sync2 = 1'b1; tick(1);
        sync2 = 1'b0; tick(1);
        check("t6_drop", {31'h0, locked2}, 32'h0);
        tick(2);
        check("t6_err1",   {24'h0, err2}, 32'd1);
        tick(506);
        check("t6_err254", {24'h0, err2}, 32'd254);
        tick(2);
        check("t6_err255", {24'h0, err2}, 32'd255);
        tick(20);
        check("t6_errsat", {24'h0, err2}, 32'd255);
        check("t6_nolock", {31'h0, locked2}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
